// File: rtl/klt_pkg.sv
// Shared types and widths for the KLT tracking datapath and its frame sequencer.
package klt_pkg;

    localparam int unsigned X_W    = 12;
    localparam int unsigned Y_W    = 11;
    localparam int unsigned MISS_W = 4;
    localparam int unsigned FCNT_W = 16;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned ST_W   = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_TRACK = 2'd2,
        ST_LOST  = 2'd3
    } st_t;

endpackage

// File: rtl/klt_track_ctrl_if.sv
// Control/status bundle between the user side and the KLT frame sequencer.
interface klt_track_ctrl_if;
    import klt_pkg::*;

    logic              start;
    logic              stop;
    logic              rx_vsync;
    logic              dx_valid;
    logic [X_W-1:0]    dx_int;
    logic [Y_W-1:0]    dy_int;
    logic              enable_tracking;
    logic              reset_position;
    logic              tracking_active;
    logic              track_lost;
    logic [MISS_W-1:0] miss_count;
    logic [FCNT_W-1:0] frame_count;
    logic [ST_W-1:0]   state;

    modport master (
        output start, stop, rx_vsync, dx_valid, dx_int, dy_int,
        input  enable_tracking, reset_position, tracking_active, track_lost,
               miss_count, frame_count, state
    );

    modport slave (
        input  start, stop, rx_vsync, dx_valid, dx_int, dy_int,
        output enable_tracking, reset_position, tracking_active, track_lost,
               miss_count, frame_count, state
    );

endinterface

// File: rtl/klt_frame_grader.sv
// Detects the vsync frame boundary and grades the displacement results seen in each frame.
module klt_frame_grader
    import klt_pkg::*;
#(
    parameter int unsigned MAX_STEP = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rx_vsync,
    input  logic           dx_valid,
    input  logic [X_W-1:0] dx_int,
    input  logic [Y_W-1:0] dy_int,
    output logic           frame_edge_c,
    output logic           frame_good_c
);

    logic           vsync_d;
    logic           good_seen;
    logic           bad_seen;
    logic [X_W-1:0] dx_mag;
    logic [Y_W-1:0] dy_mag;
    logic           step_ok;
    logic           cur_good;
    logic           cur_bad;

    // Negating the most-negative code leaves the sign bit set, which rejects it.
    assign dx_mag  = dx_int[X_W-1] ? X_W'(~dx_int + 1'b1) : dx_int;
    assign dy_mag  = dy_int[Y_W-1] ? Y_W'(~dy_int + 1'b1) : dy_int;
    assign step_ok = ~dx_mag[X_W-1] && (dx_mag <= X_W'(MAX_STEP)) &&
                     ~dy_mag[Y_W-1] && (dy_mag <= Y_W'(MAX_STEP));

    assign cur_good     = dx_valid & step_ok;
    assign cur_bad      = dx_valid & ~step_ok;
    assign frame_edge_c = rx_vsync & ~vsync_d;
    // A result arriving on the edge cycle still belongs to the frame that is ending.
    assign frame_good_c = (good_seen | cur_good) & ~(bad_seen | cur_bad);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d   <= 1'b0;
            good_seen <= 1'b0;
            bad_seen  <= 1'b0;
        end else begin
            vsync_d <= rx_vsync;
            if (frame_edge_c) begin
                good_seen <= 1'b0;
                bad_seen  <= 1'b0;
            end else begin
                good_seen <= good_seen | cur_good;
                bad_seen  <= bad_seen | cur_bad;
            end
        end
    end

endmodule

// File: rtl/klt_track_ctrl.sv
// Frame-level sequencer for the KLT tracker: arms, settles, grades frames and handles track loss.
module klt_track_ctrl
    import klt_pkg::*;
#(
    parameter int unsigned MAX_STEP      = 8,
    parameter int unsigned SETTLE_FRAMES = 2,
    parameter int unsigned MAX_MISS      = 3,
    parameter int unsigned AUTO_REACQ    = 1,
    parameter int unsigned RETRY_FRAMES  = 4
) (
    input  logic             rx_pclk,
    input  logic             rx_rst_n,
    klt_track_ctrl_if.slave  bus
);

    logic              frame_edge_c;
    logic              frame_good_c;

    st_t               st_q, st_d;
    logic [CNT_W-1:0]  settle_q, settle_d;
    logic [CNT_W-1:0]  retry_q, retry_d;
    logic [CNT_W-1:0]  retry_inc;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic [MISS_W-1:0] miss_inc;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              en_q, en_d;
    logic              rp_q, rp_d;
    logic              ta_q, ta_d;
    logic              tl_q, tl_d;

    klt_frame_grader #(
        .MAX_STEP (MAX_STEP)
    ) u_grader (
        .clk          (rx_pclk),
        .rst_n        (rx_rst_n),
        .rx_vsync     (bus.rx_vsync),
        .dx_valid     (bus.dx_valid),
        .dx_int       (bus.dx_int),
        .dy_int       (bus.dy_int),
        .frame_edge_c (frame_edge_c),
        .frame_good_c (frame_good_c)
    );

    assign miss_inc  = (miss_q == '1) ? miss_q : miss_q + 1'b1;
    assign retry_inc = retry_q + 1'b1;

    // SETTLE and TRACK share one state; a nonzero settle count means grading is suppressed.
    always_comb begin
        st_d     = st_q;
        settle_d = settle_q;
        retry_d  = retry_q;
        miss_d   = miss_q;
        fcnt_d   = fcnt_q;

        if (bus.stop) begin
            st_d   = ST_IDLE;
            miss_d = '0;
        end else begin
            unique case (st_q)
                ST_IDLE: begin
                    if (bus.start) st_d = ST_ARM;
                end
                ST_ARM: begin
                    if (frame_edge_c) begin
                        st_d     = ST_TRACK;
                        miss_d   = '0;
                        fcnt_d   = '0;
                        settle_d = CNT_W'(SETTLE_FRAMES);
                    end
                end
                ST_TRACK: begin
                    if (frame_edge_c) begin
                        if (fcnt_q != '1) fcnt_d = fcnt_q + 1'b1;
                        if (settle_q != '0) begin
                            settle_d = settle_q - 1'b1;
                        end else if (frame_good_c) begin
                            miss_d = '0;
                        end else begin
                            miss_d = miss_inc;
                            if (miss_inc == MISS_W'(MAX_MISS)) begin
                                st_d    = ST_LOST;
                                retry_d = '0;
                            end
                        end
                    end
                end
                ST_LOST: begin
                    if (bus.start) begin
                        st_d = ST_ARM;
                    end else if ((AUTO_REACQ != 0) && frame_edge_c) begin
                        if (retry_inc >= CNT_W'(RETRY_FRAMES)) st_d = ST_ARM;
                        else                                   retry_d = retry_inc;
                    end
                end
                default: st_d = ST_IDLE;
            endcase
        end

        en_d = (st_d == ST_TRACK);
        ta_d = (st_d == ST_TRACK);
        rp_d = (st_d == ST_ARM);
        tl_d = (st_d == ST_LOST);
    end

    always_ff @(posedge rx_pclk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            st_q     <= ST_IDLE;
            settle_q <= '0;
            retry_q  <= '0;
            miss_q   <= '0;
            fcnt_q   <= '0;
            en_q     <= 1'b0;
            rp_q     <= 1'b0;
            ta_q     <= 1'b0;
            tl_q     <= 1'b0;
        end else begin
            st_q     <= st_d;
            settle_q <= settle_d;
            retry_q  <= retry_d;
            miss_q   <= miss_d;
            fcnt_q   <= fcnt_d;
            en_q     <= en_d;
            rp_q     <= rp_d;
            ta_q     <= ta_d;
            tl_q     <= tl_d;
        end
    end

    assign bus.enable_tracking = en_q;
    assign bus.reset_position  = rp_q;
    assign bus.tracking_active = ta_q;
    assign bus.track_lost      = tl_q;
    assign bus.miss_count      = miss_q;
    assign bus.frame_count     = fcnt_q;
    assign bus.state           = ST_W'(st_q);

endmodule

// File: tb/tb_klt_track_ctrl.sv
// Directed bench for klt_track_ctrl: arming, settling, grading, loss/re-acquire, stop and reset.
module tb_klt_track_ctrl;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    klt_track_ctrl_if tif ();

    klt_track_ctrl #(
        .MAX_STEP      (8),
        .SETTLE_FRAMES (2),
        .MAX_MISS      (3),
        .AUTO_REACQ    (1),
        .RETRY_FRAMES  (4)
    ) dut (
        .rx_pclk  (clk),
        .rx_rst_n (rst_n),
        .bus      (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic send_dx(input int dx, input int dy);
        tif.dx_valid = 1'b1;
        tif.dx_int   = 12'(dx);
        tif.dy_int   = 11'(dy);
        cyc();
        tif.dx_valid = 1'b0;
    endtask

    // Rising vsync; returns just after the edge cycle has been clocked.
    task automatic vs_pulse();
        tif.rx_vsync = 1'b1;
        cyc();
        tif.rx_vsync = 1'b0;
    endtask

    task automatic vs_pulse_dx(input int dx, input int dy);
        tif.rx_vsync = 1'b1;
        tif.dx_valid = 1'b1;
        tif.dx_int   = 12'(dx);
        tif.dy_int   = 11'(dy);
        cyc();
        tif.rx_vsync = 1'b0;
        tif.dx_valid = 1'b0;
    endtask

    task automatic frame(input bit with_dx, input int dx, input int dy);
        gap(2);
        if (with_dx) send_dx(dx, dy);
        gap(2);
        vs_pulse();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        gap(3);
        n_chk++; if (tif.state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", tif.state); else n_pass++;
        n_chk++; if ({tif.enable_tracking, tif.reset_position, tif.tracking_active, tif.track_lost} !== 4'b0)
            $display("FAIL reset_flags got=%b exp=0000", {tif.enable_tracking, tif.reset_position, tif.tracking_active, tif.track_lost}); else n_pass++;
        n_chk++; if ({tif.miss_count, tif.frame_count} !== 20'd0)
            $display("FAIL reset_counts got=%0d/%0d exp=0/0", tif.miss_count, tif.frame_count); else n_pass++;
        rst_n = 1'b1;
        gap(2);
    endtask

    task automatic test_start_settle();
        tif.start = 1'b1;
        cyc();
        tif.start = 1'b0;
        n_chk++; if (tif.state !== 2'd1) $display("FAIL arm_state got=%0d exp=1", tif.state); else n_pass++;
        gap(2);
        send_dx(2, -1);
        gap(2);
        n_chk++; if ({tif.reset_position, tif.enable_tracking} !== 2'b10)
            $display("FAIL arm_outputs got=%b exp=10", {tif.reset_position, tif.enable_tracking}); else n_pass++;
        vs_pulse();
        n_chk++; if ({tif.reset_position, tif.enable_tracking, tif.tracking_active} !== 3'b011)
            $display("FAIL settle_enter got=%b exp=011", {tif.reset_position, tif.enable_tracking, tif.tracking_active}); else n_pass++;
        n_chk++; if (tif.state !== 2'd2) $display("FAIL settle_state got=%0d exp=2", tif.state); else n_pass++;
        n_chk++; if (tif.frame_count !== 16'd0) $display("FAIL settle_fc0 got=%0d exp=0", tif.frame_count); else n_pass++;
        frame(1, 2, -1);
        n_chk++; if (tif.frame_count !== 16'd1) $display("FAIL settle_fc1 got=%0d exp=1", tif.frame_count); else n_pass++;
        frame(1, 2, -1);
        n_chk++; if (tif.frame_count !== 16'd2) $display("FAIL settle_fc2 got=%0d exp=2", tif.frame_count); else n_pass++;
        n_chk++; if (tif.miss_count !== 4'd0) $display("FAIL settle_miss got=%0d exp=0", tif.miss_count); else n_pass++;
    endtask

    task automatic test_loss_reacq();
        frame(0, 0, 0);
        n_chk++; if (tif.miss_count !== 4'd1) $display("FAIL loss_miss1 got=%0d exp=1", tif.miss_count); else n_pass++;
        frame(0, 0, 0);
        n_chk++; if (tif.miss_count !== 4'd2) $display("FAIL loss_miss2 got=%0d exp=2", tif.miss_count); else n_pass++;
        frame(0, 0, 0);
        n_chk++; if (tif.miss_count !== 4'd3) $display("FAIL loss_miss3 got=%0d exp=3", tif.miss_count); else n_pass++;
        n_chk++; if ({tif.state, tif.track_lost, tif.enable_tracking} !== 4'b1110)
            $display("FAIL loss_enter got=%b exp=1110", {tif.state, tif.track_lost, tif.enable_tracking}); else n_pass++;
        n_chk++; if (tif.frame_count !== 16'd5) $display("FAIL loss_fc got=%0d exp=5", tif.frame_count); else n_pass++;
        for (int i = 0; i < 3; i++) frame(0, 0, 0);
        n_chk++; if ({tif.state, tif.frame_count} !== {2'd3, 16'd5})
            $display("FAIL lost_hold got=%0d/%0d exp=3/5", tif.state, tif.frame_count); else n_pass++;
        frame(0, 0, 0);
        n_chk++; if ({tif.state, tif.reset_position, tif.track_lost} !== 4'b0110)
            $display("FAIL reacq got=%b exp=0110", {tif.state, tif.reset_position, tif.track_lost}); else n_pass++;
        n_chk++; if (tif.miss_count !== 4'd3) $display("FAIL reacq_miss_hold got=%0d exp=3", tif.miss_count); else n_pass++;
    endtask

    task automatic test_grading();
        frame(0, 0, 0);
        n_chk++; if ({tif.miss_count, tif.frame_count} !== {4'd0, 16'd0})
            $display("FAIL rearm_clear got=%0d/%0d exp=0/0", tif.miss_count, tif.frame_count); else n_pass++;
        frame(0, 0, 0);
        frame(0, 0, 0);
        gap(2);
        send_dx(-9, 0);
        send_dx(1, 0);
        gap(1);
        vs_pulse();
        n_chk++; if (tif.miss_count !== 4'd1) $display("FAIL bad_then_good got=%0d exp=1", tif.miss_count); else n_pass++;
        frame(1, 3, 3);
        n_chk++; if (tif.miss_count !== 4'd0) $display("FAIL good_clears got=%0d exp=0", tif.miss_count); else n_pass++;
        frame(1, -2048, 0);
        n_chk++; if (tif.miss_count !== 4'd1) $display("FAIL most_negative got=%0d exp=1", tif.miss_count); else n_pass++;
        frame(1, 8, -8);
        n_chk++; if (tif.miss_count !== 4'd0) $display("FAIL step_boundary got=%0d exp=0", tif.miss_count); else n_pass++;
        frame(1, 0, 9);
        n_chk++; if (tif.miss_count !== 4'd1) $display("FAIL dy_over got=%0d exp=1", tif.miss_count); else n_pass++;
        n_chk++; if (tif.frame_count !== 16'd7) $display("FAIL grade_fc got=%0d exp=7", tif.frame_count); else n_pass++;
    endtask

    task automatic test_edge_credit();
        frame(0, 0, 0);
        n_chk++; if (tif.miss_count !== 4'd2) $display("FAIL credit_pre got=%0d exp=2", tif.miss_count); else n_pass++;
        gap(3);
        vs_pulse_dx(2, -1);
        n_chk++; if ({tif.miss_count, tif.state} !== {4'd0, 2'd2})
            $display("FAIL edge_credit got=%0d/%0d exp=0/2", tif.miss_count, tif.state); else n_pass++;
        n_chk++; if (tif.frame_count !== 16'd9) $display("FAIL credit_fc got=%0d exp=9", tif.frame_count); else n_pass++;
    endtask

    task automatic test_stop_start();
        gap(2);
        frame(0, 0, 0);
        n_chk++; if (tif.miss_count !== 4'd1) $display("FAIL stop_pre got=%0d exp=1", tif.miss_count); else n_pass++;
        tif.stop  = 1'b1;
        tif.start = 1'b1;
        cyc();
        tif.stop  = 1'b0;
        tif.start = 1'b0;
        n_chk++; if ({tif.state, tif.enable_tracking, tif.tracking_active} !== 4'b0000)
            $display("FAIL stop_idle got=%b exp=0000", {tif.state, tif.enable_tracking, tif.tracking_active}); else n_pass++;
        n_chk++; if ({tif.miss_count, tif.frame_count} !== {4'd0, 16'd10})
            $display("FAIL stop_counts got=%0d/%0d exp=0/10", tif.miss_count, tif.frame_count); else n_pass++;
        frame(0, 0, 0);
        n_chk++; if ({tif.state, tif.frame_count} !== {2'd0, 16'd10})
            $display("FAIL idle_hold got=%0d/%0d exp=0/10", tif.state, tif.frame_count); else n_pass++;
    endtask

    task automatic test_reset_in_lost();
        tif.start = 1'b1;
        cyc();
        tif.start = 1'b0;
        for (int i = 0; i < 6; i++) frame(0, 0, 0);
        n_chk++; if ({tif.state, tif.track_lost, tif.frame_count} !== {2'd3, 1'b1, 16'd5})
            $display("FAIL lost_again got=%0d/%0d/%0d exp=3/1/5", tif.state, tif.track_lost, tif.frame_count); else n_pass++;
        gap(2);
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if ({tif.state, tif.track_lost, tif.reset_position, tif.enable_tracking, tif.tracking_active} !== 6'd0)
            $display("FAIL async_reset_flags got=%0d/%b exp=0/0000", tif.state,
                     {tif.track_lost, tif.reset_position, tif.enable_tracking, tif.tracking_active}); else n_pass++;
        n_chk++; if ({tif.miss_count, tif.frame_count} !== 20'd0)
            $display("FAIL async_reset_counts got=%0d/%0d exp=0/0", tif.miss_count, tif.frame_count); else n_pass++;
        cyc();
        rst_n = 1'b1;
        gap(2);
    endtask

    initial begin
        n_chk        = 0;
        n_pass       = 0;
        rst_n        = 1'b0;
        tif.start    = 1'b0;
        tif.stop     = 1'b0;
        tif.rx_vsync = 1'b0;
        tif.dx_valid = 1'b0;
        tif.dx_int   = '0;
        tif.dy_int   = '0;
        test_reset();
        test_start_settle();
        test_loss_reacq();
        test_grading();
        test_edge_credit();
        test_stop_start();
        test_reset_in_lost();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
